// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master controller: state encoding,
// response codes and the one-hot select check.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [1:0] APB_RESP_OK      = 2'b00;
    localparam logic [1:0] APB_RESP_SLVERR  = 2'b01;
    localparam logic [1:0] APB_RESP_TIMEOUT = 2'b10;
    localparam logic [1:0] APB_RESP_DECERR  = 2'b11;

    // True when exactly one bit is set; callers zero-extend selects up to 32 bits.
    function automatic logic apb_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog for the APB master: counts cycles while run is high and
// flags the last permitted cycle. Cleared whenever run is low.
module apb_timeout_cnt #(
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = run ? cnt_q + CW'(1) : '0;
        expired = run && (cnt_q == CW'(TO_CYCLES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3/APB4 master: one request at a time, SETUP/ACCESS sequencing, registered
// single-cycle response. Optional ACCESS timeout enabled by APB_TIMEOUT_EN.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned NSLV      = 3,
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic              Pclk,
    input  logic              Presetn,
    input  logic              p_req_valid,
    output logic              p_req_ready,
    input  logic [AW-1:0]     p_req_addr,
    input  logic [DW-1:0]     p_req_wdata,
    input  logic [DW/8-1:0]   p_req_strb,
    input  logic              p_req_write,
    input  logic [NSLV-1:0]   p_req_sel,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [AW-1:0]     Paddr,
    output logic [DW-1:0]     Pwdata,
    output logic [DW/8-1:0]   Pstrb,
    input  logic [DW-1:0]     Prdata,
    input  logic              Pready,
    input  logic              Pslverr,
    output logic              p_resp_valid,
    output logic [DW-1:0]     p_resp_rdata,
    output logic [1:0]        p_resp_err
);

    apb_state_e state_q, state_d;

    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] strb_q;
    logic            write_q;
    logic [NSLV-1:0] sel_q;

    logic            resp_valid_q, resp_valid_d;
    logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
    logic [1:0]      resp_err_q, resp_err_d;
    logic            dec_pend_q, dec_pend_d;

    logic accept, sel_ok, capture, bad_sel, complete, expired;

`ifdef APB_TIMEOUT_EN
    apb_timeout_cnt #(
        .TO_CYCLES (TO_CYCLES)
    ) u_timeout (
        .clk     (Pclk),
        .rst_n   (Presetn),
        .run     (state_q == ACCESS),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        complete    = (state_q == ACCESS) && Pready;
        p_req_ready = Presetn && ((state_q == IDLE) || complete);
        accept      = p_req_valid && p_req_ready;
        sel_ok      = apb_onehot(32'(p_req_sel));
        capture     = accept && sel_ok;
        bad_sel     = accept && !sel_ok;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (Pready) begin
                    state_d = capture ? SETUP : IDLE;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A bad select accepted on a completion edge collides with that completion's
    // response, so its DECERR is deferred by one cycle.
    always_comb begin
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = APB_RESP_OK;
        dec_pend_d   = 1'b0;
        if (complete) begin
            resp_valid_d = 1'b1;
            resp_err_d   = Pslverr ? APB_RESP_SLVERR : APB_RESP_OK;
            resp_rdata_d = (!write_q && !Pslverr) ? Prdata : '0;
            dec_pend_d   = bad_sel;
        end else if ((state_q == ACCESS) && expired) begin
            resp_valid_d = 1'b1;
            resp_err_d   = APB_RESP_TIMEOUT;
        end else if (dec_pend_q || bad_sel) begin
            resp_valid_d = 1'b1;
            resp_err_d   = APB_RESP_DECERR;
            dec_pend_d   = dec_pend_q && bad_sel;
        end
    end

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            write_q      <= 1'b0;
            sel_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= APB_RESP_OK;
            dec_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            dec_pend_q   <= dec_pend_d;
            if (capture) begin
                addr_q  <= p_req_addr;
                wdata_q <= p_req_wdata;
                strb_q  <= p_req_strb;
                write_q <= p_req_write;
                sel_q   <= p_req_sel;
            end
        end
    end

    always_comb begin
        Pselx        = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
        Penable      = (state_q == ACCESS);
        Pwrite       = write_q;
        Paddr        = addr_q;
        Pwdata       = wdata_q;
        Pstrb        = write_q ? strb_q : '0;
        p_resp_valid = resp_valid_q;
        p_resp_rdata = resp_rdata_q;
        p_resp_err   = resp_err_q;
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with a response scoreboard; timeout cases
// are exercised when APB_TIMEOUT_EN is defined.
module tb_apb_master_ctrl;
    import apb_pkg::*;

    logic        Pclk = 1'b0;
    logic        Presetn = 1'b0;
    logic        p_req_valid = 1'b0;
    logic        p_req_ready;
    logic [31:0] p_req_addr = '0;
    logic [31:0] p_req_wdata = '0;
    logic [3:0]  p_req_strb = '0;
    logic        p_req_write = 1'b0;
    logic [2:0]  p_req_sel = '0;
    logic [2:0]  Pselx;
    logic        Penable, Pwrite;
    logic [31:0] Paddr, Pwdata;
    logic [3:0]  Pstrb;
    logic [31:0] Prdata = '0;
    logic        Pready = 1'b0;
    logic        Pslverr = 1'b0;
    logic        p_resp_valid;
    logic [31:0] p_resp_rdata;
    logic [1:0]  p_resp_err;

    int checks = 0;
    int fails = 0;
    logic [33:0] sb_q[$];
    logic [33:0] sb_e;

    always #5 Pclk = ~Pclk;

    apb_master_ctrl #(
        .AW (32), .DW (32), .NSLV (3), .TO_CYCLES (16)
    ) dut (
        .Pclk (Pclk), .Presetn (Presetn),
        .p_req_valid (p_req_valid), .p_req_ready (p_req_ready),
        .p_req_addr (p_req_addr), .p_req_wdata (p_req_wdata),
        .p_req_strb (p_req_strb), .p_req_write (p_req_write), .p_req_sel (p_req_sel),
        .Pselx (Pselx), .Penable (Penable), .Pwrite (Pwrite), .Paddr (Paddr),
        .Pwdata (Pwdata), .Pstrb (Pstrb), .Prdata (Prdata), .Pready (Pready),
        .Pslverr (Pslverr), .p_resp_valid (p_resp_valid),
        .p_resp_rdata (p_resp_rdata), .p_resp_err (p_resp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge Pclk) begin
        if (Presetn && p_resp_valid) begin
            if (sb_q.size() == 0) begin
                check("resp_unexpected", 64'(p_resp_valid), 64'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check("resp_err", 64'(p_resp_err), 64'(sb_e[33:32]));
                check("resp_rdata", 64'(p_resp_rdata), 64'(sb_e[31:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // One full transfer starting from IDLE at a negedge; leaves the bench at the
    // negedge where the response is visible.
    task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input logic wr, input logic [2:0] sel, input int waits,
                        input logic [31:0] rd, input logic serr);
        p_req_valid = 1'b1; p_req_addr = a; p_req_wdata = wd; p_req_strb = st;
        p_req_write = wr; p_req_sel = sel; Pready = 1'b0; Pslverr = 1'b0; Prdata = rd;
        #1 check("ready_idle", 64'(p_req_ready), 64'd1);
        sb_q.push_back({serr ? APB_RESP_SLVERR : APB_RESP_OK, (wr || serr) ? 32'h0 : rd});
        @(negedge Pclk);
        // Scramble the request bus to prove APB outputs come from captured state.
        p_req_valid = 1'b0; p_req_addr = ~a; p_req_wdata = ~wd; p_req_strb = ~st;
        p_req_write = ~wr; p_req_sel = ~sel;
        check("setup_sel", 64'(Pselx), 64'(sel));
        check("setup_enable", 64'(Penable), 64'd0);
        check("setup_addr", 64'(Paddr), 64'(a));
        check("setup_wdata", 64'(Pwdata), 64'(wd));
        check("setup_strb", 64'(Pstrb), 64'(wr ? st : 4'h0));
        check("setup_write", 64'(Pwrite), 64'(wr));
        for (int i = 0; i <= waits; i++) begin
            @(negedge Pclk);
            check("access_enable", 64'(Penable), 64'd1);
            check("access_sel", 64'(Pselx), 64'(sel));
            check("access_addr", 64'(Paddr), 64'(a));
            check("access_wdata", 64'(Pwdata), 64'(wd));
            Pready = (i == waits);
            Pslverr = serr && (i == waits);
            #1 check("ready_access", 64'(p_req_ready), 64'(i == waits));
        end
        @(negedge Pclk);
        check("resp_valid", 64'(p_resp_valid), 64'd1);
        check("idle_sel", 64'(Pselx), 64'd0);
        check("idle_enable", 64'(Penable), 64'd0);
        check("idle_addr_hold", 64'(Paddr), 64'(a));
        check("idle_write_hold", 64'(Pwrite), 64'(wr));
        Pready = 1'b0; Pslverr = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_sel", 64'(Pselx), 64'd0);
        check("rst_enable", 64'(Penable), 64'd0);
        check("rst_addr", 64'(Paddr), 64'd0);
        check("rst_ready", 64'(p_req_ready), 64'd0);
        check("rst_resp_valid", 64'(p_resp_valid), 64'd0);
        check("rst_resp_err", 64'(p_resp_err), 64'd0);
        @(negedge Pclk); @(negedge Pclk);
        Presetn = 1'b1;

        // Zero-wait write, 3-wait read, slave error on a read.
        xfer(32'h1000, 32'hDEADBEEF, 4'hF, 1'b1, 3'b010, 0, 32'h0, 1'b0);
        xfer(32'h1004, 32'h0, 4'h0, 1'b0, 3'b001, 3, 32'hCAFEF00D, 1'b0);
        xfer(32'h1008, 32'h0, 4'h0, 1'b0, 3'b100, 1, 32'h55AA55AA, 1'b1);

        // Back-to-back write then read.
        p_req_valid = 1'b1; p_req_addr = 32'h2000; p_req_wdata = 32'h11223344;
        p_req_strb = 4'h3; p_req_write = 1'b1; p_req_sel = 3'b001; Pready = 1'b0;
        sb_q.push_back({APB_RESP_OK, 32'h0});
        @(negedge Pclk);
        check("b2b_setup1_sel", 64'(Pselx), 64'd1);
        check("b2b_setup1_ready", 64'(p_req_ready), 64'd0);
        p_req_addr = 32'h3000; p_req_write = 1'b0; p_req_sel = 3'b100; p_req_wdata = '0;
        Prdata = 32'hABCD1234; Pready = 1'b1;
        sb_q.push_back({APB_RESP_OK, 32'hABCD1234});
        @(negedge Pclk);
        check("b2b_access1_enable", 64'(Penable), 64'd1);
        check("b2b_access1_strb", 64'(Pstrb), 64'h3);
        check("b2b_access1_ready", 64'(p_req_ready), 64'd1);
        @(negedge Pclk);
        p_req_valid = 1'b0;
        check("b2b_setup2_sel", 64'(Pselx), 64'd4);
        check("b2b_setup2_enable", 64'(Penable), 64'd0);
        check("b2b_setup2_addr", 64'(Paddr), 64'h3000);
        check("b2b_setup2_strb", 64'(Pstrb), 64'd0);
        check("b2b_resp1_valid", 64'(p_resp_valid), 64'd1);
        @(negedge Pclk);
        check("b2b_access2_enable", 64'(Penable), 64'd1);
        check("b2b_gap_valid", 64'(p_resp_valid), 64'd0);
        @(negedge Pclk);
        check("b2b_resp2_valid", 64'(p_resp_valid), 64'd1);
        check("b2b_idle_sel", 64'(Pselx), 64'd0);
        Pready = 1'b0;

        // Zero and multi-hot selects.
        p_req_valid = 1'b1; p_req_sel = 3'b000;
        sb_q.push_back({APB_RESP_DECERR, 32'h0});
        @(negedge Pclk);
        check("dec0_sel", 64'(Pselx), 64'd0);
        check("dec0_valid", 64'(p_resp_valid), 64'd1);
        check("dec0_ready", 64'(p_req_ready), 64'd1);
        p_req_sel = 3'b011;
        sb_q.push_back({APB_RESP_DECERR, 32'h0});
        @(negedge Pclk);
        p_req_valid = 1'b0;
        check("dec3_sel", 64'(Pselx), 64'd0);
        check("dec3_enable", 64'(Penable), 64'd0);
        check("dec3_valid", 64'(p_resp_valid), 64'd1);
        @(negedge Pclk);
        check("dec_after_valid", 64'(p_resp_valid), 64'd0);

`ifdef APB_TIMEOUT_EN
        // Slave never ready: terminated after 16 ACCESS cycles.
        p_req_valid = 1'b1; p_req_addr = 32'h5000; p_req_write = 1'b0; p_req_sel = 3'b001;
        Prdata = 32'h77777777; Pready = 1'b0;
        sb_q.push_back({APB_RESP_TIMEOUT, 32'h0});
        @(negedge Pclk);
        p_req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge Pclk);
            check("to_enable", 64'(Penable), 64'd1);
        end
        @(negedge Pclk);
        check("to_resp_valid", 64'(p_resp_valid), 64'd1);
        check("to_sel", 64'(Pselx), 64'd0);
        check("to_enable_drop", 64'(Penable), 64'd0);
        // Ready on the 16th ACCESS cycle beats expiry.
        xfer(32'h5004, 32'h0, 4'h0, 1'b0, 3'b010, 15, 32'h13572468, 1'b0);
`else
        // Long wait with no timeout in the default build.
        xfer(32'h5004, 32'h0, 4'h0, 1'b0, 3'b010, 20, 32'h13572468, 1'b0);
`endif

        // Reset asserted mid-ACCESS discards the transfer.
        p_req_valid = 1'b1; p_req_addr = 32'h4000; p_req_wdata = 32'h99999999;
        p_req_strb = 4'hF; p_req_write = 1'b1; p_req_sel = 3'b100; Pready = 1'b0;
        @(negedge Pclk);
        @(negedge Pclk);
        check("rst2_pre_enable", 64'(Penable), 64'd1);
        Presetn = 1'b0;
        #1;
        check("rst2_sel", 64'(Pselx), 64'd0);
        check("rst2_enable", 64'(Penable), 64'd0);
        check("rst2_addr", 64'(Paddr), 64'd0);
        check("rst2_wdata", 64'(Pwdata), 64'd0);
        check("rst2_write", 64'(Pwrite), 64'd0);
        check("rst2_strb", 64'(Pstrb), 64'd0);
        check("rst2_ready", 64'(p_req_ready), 64'd0);
        check("rst2_resp_valid", 64'(p_resp_valid), 64'd0);
        @(negedge Pclk);
        p_req_valid = 1'b0;
        Presetn = 1'b1;
        @(negedge Pclk);
        check("rst2_after_valid", 64'(p_resp_valid), 64'd0);
        xfer(32'h6000, 32'h0, 4'h0, 1'b0, 3'b100, 2, 32'h2468ACE0, 1'b0);

        @(negedge Pclk);
        @(negedge Pclk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

Parametrised APB master controller. Accepts one request at a time from the bridge-side request channel, drives a full APB3/APB4 SETUP/ACCESS sequence to one of `NSLV` slaves, and returns a single-cycle response with read data and an error code. Successor to the fixed 32-bit, 3-slave, zero-wait controller. Adds wait states via `Pready`, `Pslverr`, write strobes, select decode checking, back-to-back transfers, and an optional access timeout.

## Interface
Parameters:
- `AW`, default 32: address width.
- `DW`, default 32: data width; must be a multiple of 8.
- `NSLV`, default 3: number of slaves; width of the one-hot select.
- `TO_CYCLES`, default 16: maximum ACCESS cycles before timeout. Only used with `APB_TIMEOUT_EN`; must be ≥2.

Ports:
- `Pclk` input 1: clock. All logic is on the rising edge.
- `Presetn` input 1: asynchronous, active-low reset.
- `p_req_valid` input 1: request present.
- `p_req_ready` output 1: request accepted when `p_req_valid & p_req_ready` at a rising edge.
- `p_req_addr` input AW: target address.
- `p_req_wdata` input DW: write data.
- `p_req_strb` input DW/8: write byte strobes.
- `p_req_write` input 1: 1 = write, 0 = read.
- `p_req_sel` input NSLV: one-hot slave select.
- `Pselx` output NSLV: APB select.
- `Penable` output 1: APB enable.
- `Pwrite` output 1: APB direction.
- `Paddr` output AW: APB address.
- `Pwdata` output DW: APB write data.
- `Pstrb` output DW/8: APB strobes; forced to 0 on reads.
- `Prdata` input DW: slave read data.
- `Pready` input 1: slave ready.
- `Pslverr` input 1: slave error; sampled only with `Pready`.
- `p_resp_valid` output 1: one-cycle response pulse.
- `p_resp_rdata` output DW: read data. 0 for writes and for any error.
- `p_resp_err` output 2: response code. 00 = OK, 01 = SLVERR, 10 = TIMEOUT, 11 = DECERR.

## Operation
- States: `IDLE`, `SETUP`, `ACCESS`.
- On acceptance, the request fields are captured into registers. APB address, data, strobe, write and select outputs are driven only from these registers, never from `p_req_*`.
- `IDLE` → `SETUP` on acceptance with a valid select (exactly one bit set).
- Accepted select that is zero or multi-hot:
  - No APB cycle is issued and the state stays `IDLE`.
  - The next cycle gives `p_resp_valid=1` with err=11.
- `SETUP`: `Pselx` = captured select, `Penable=0`. Always → `ACCESS` after one cycle.
- `ACCESS`: `Penable=1`; all APB outputs are held stable until completion.
  - Completion is `Pready=1` at an edge.
  - err = 01 if `Pslverr`, else 00.
  - `p_resp_rdata` = `Prdata` on a successful read.
- `p_req_ready`:
  - 1 in `IDLE`.
  - 1 in `ACCESS` in the completing cycle (`Pready=1`), allowing a back-to-back transfer: `ACCESS` → `SETUP` with no idle cycle.
  - 0 otherwise.
  - Forced 0 while `Presetn=0`.
- After completion with no new request: `ACCESS` → `IDLE`. `Pselx` and `Penable` drop to 0; `Paddr`, `Pwdata` and `Pwrite` hold their last values.
- Reset (asynchronous, any state): state = `IDLE`, and every output is 0. An in-flight transfer is discarded and no response is produced.
- Illegal state encoding → `IDLE`.

## Timing
- Acceptance edge = T0.
  - T0→T1: `SETUP`.
  - T1→T2: `ACCESS`.
  - `Pready` sampled at the end of T2 or later.
- `p_resp_valid`, `p_resp_rdata` and `p_resp_err` are registered. They are valid the cycle after the completion edge, for exactly one cycle.
- Zero-wait slave: acceptance to response is 3 cycles. Each wait state adds 1.
- Back-to-back transfers: one transfer per 2 `Pclk` with a zero-wait slave.
- DECERR response arrives 1 cycle after acceptance. Its `p_req_ready` stays 1 throughout.

## Configuration
`APB_TIMEOUT_EN`:
- Defined:
  - A counter runs in `ACCESS`, cleared on entry.
  - If `TO_CYCLES` ACCESS cycles elapse without `Pready`, the transfer is terminated: → `IDLE`, `Pselx` and `Penable` drop, and the response has err=10 with rdata 0.
  - `Pready` in the same cycle as expiry wins, giving normal completion.
- Undefined: no counter; `ACCESS` waits indefinitely and err=10 is never produced.

## Structure
- Package `apb_pkg` holds:
  - the state enum `apb_state_e`;
  - the response-code constants `APB_RESP_OK`, `APB_RESP_SLVERR`, `APB_RESP_TIMEOUT`, `APB_RESP_DECERR`;
  - the one-hot check function `apb_onehot`.
- One sub-module, `apb_timeout_cnt`, holds the timeout counter. It is instantiated only under `APB_TIMEOUT_EN`.

## Test plan
- Zero-wait write: addr 0x1000, wdata 0xDEADBEEF, strb 0xF, sel 3'b010.
  - `Pselx`=010 at T1, `Penable` at T2.
  - `p_resp_valid` at T3 with err 00 and rdata 0.
- Read with 3 wait states, `Prdata`=0xCAFEF00D.
  - APB outputs stable across T2..T5.
  - Response at T6: rdata 0xCAFEF00D, err 00.
- Back-to-back write then read, each with `Pready=1`.
  - Second `SETUP` immediately after the first `ACCESS`.
  - Two responses 2 cycles apart.
- `Pslverr=1` with `Pready` on a read gives err 01 and rdata 0. Select 3'b000 or 3'b011 gives no `Pselx` activity and err 11 one cycle later.
- With `APB_TIMEOUT_EN`, `TO_CYCLES`=16 and `Pready` held low:
  - Termination after 16 ACCESS cycles, err 10.
  - `Pready` in the 16th cycle gives err 00.
- `Presetn` pulled low in `ACCESS`:
  - All outputs 0 immediately, with no response.
  - After release, a new request completes normally.
